hazard_ctrl: RTL

//  Central hazard unit for the 5-stage RV32I pipeline. Drives bubble (hold) and flush (clear)

---
 rtl/hazard_ctrl_if.sv | 30 +++
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard bus: register ids and instruction flags into the
// hazard unit, per-stage bubble/flush controls and forwarding selects out.
interface hazard_ctrl_if;
  logic [4:0] reg1_src_D, reg2_src_D;
  logic [4:0] reg1_src_E, reg2_src_E;
  logic [4:0] reg_dest_E, reg_dest_M, reg_dest_W;
  logic       load_E, reg_write_M, reg_write_W;
  logic       br_taken_E, jalr_E, jal_D;
  logic       bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
  logic       flushF, flushD, flushE, flushM, flushW;
  logic [1:0] op1_sel, op2_sel;

  // Pipeline side: supplies instruction info, consumes controls.
  modport master (
    output reg1_src_D, reg2_src_D, reg1_src_E, reg2_src_E,
           reg_dest_E, reg_dest_M, reg_dest_W,
           load_E, reg_write_M, reg_write_W, br_taken_E, jalr_E, jal_D,
    input  bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
           flushF, flushD, flushE, flushM, flushW, op1_sel, op2_sel
  );

  // Hazard unit side.
  modport slave (
    input  reg1_src_D, reg2_src_D, reg1_src_E, reg2_src_E,
           reg_dest_E, reg_dest_M, reg_dest_W,
           load_E, reg_write_M, reg_write_W, br_taken_E, jalr_E, jal_D,
    output bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
           flushF, flushD, flushE, flushM, flushW, op1_sel, op2_sel
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage RV32I pipeline: stage bubble/flush control,
// EX operand forwarding, dcache-miss sequencing with watchdog, and a
// saturating stall-cycle counter.

// Per-operand forwarding select: MEM result beats WB result, x0 never forwards.
module hazard_fwd (
  input  logic [4:0] src_e,
  input  logic [4:0] dest_m,
  input  logic [4:0] dest_w,
  input  logic       wr_m,
  input  logic       wr_w,
  output logic [1:0] sel
);
  // Pick the youngest in-flight producer of this operand.
  always_comb begin
    sel = 2'b00;
    if (wr_m && dest_m != 5'd0 && dest_m == src_e)      sel = 2'b10;
    else if (wr_w && dest_w != 5'd0 && dest_w == src_e) sel = 2'b01;
  end
endmodule

module hazard_ctrl #(
  parameter int MISS_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_ctrl_if.slave     hz,
  input  logic             miss_req,
  input  logic             mem_ready,
  input  logic             stat_clr,
  output logic             err,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int NUM_OPS = 2;
  localparam int MC_W    = $clog2(MISS_TIMEOUT);
  localparam logic [MC_W-1:0]  MC_LAST = MC_W'(MISS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {RUN = 2'd0, MISS = 2'd1, ERR = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [MC_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

  logic               stall_all, load_use;
  logic [4:0]         bub, fl;  // {F,D,E,M,W}
  logic [NUM_OPS-1:0][4:0] src_e;
  logic [NUM_OPS-1:0][1:0] fwd_sel;

  // State, watchdog, error flag and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      miss_cnt_q     <= '0;
      err_q          <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      miss_cnt_q     <= miss_cnt_d;
      err_q          <= err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Miss sequencing: a miss answered in the same cycle never leaves RUN;
  // data return beats the watchdog on the last allowed cycle.
  always_comb begin
    state_d    = state_q;
    miss_cnt_d = miss_cnt_q;
    err_d      = err_q;
    unique case (state_q)
      RUN: begin
        if (miss_req && !mem_ready) begin
          state_d    = MISS;
          miss_cnt_d = '0;
        end
      end
      MISS: begin
        if (mem_ready) begin
          state_d    = RUN;
          miss_cnt_d = '0;
        end else if (miss_cnt_q == MC_LAST) begin
          state_d    = ERR;
          miss_cnt_d = '0;
          err_d      = 1'b1;
        end else begin
          miss_cnt_d = miss_cnt_q + 1'b1;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  // Stage controls by priority: memory stall, redirect, load-use, JAL.
  always_comb begin
    bub       = 5'b00000;
    fl        = 5'b00000;
    stall_all = (state_q == ERR) || (miss_req && !mem_ready);
    load_use  = hz.load_E && hz.reg_dest_E != 5'd0 &&
                (hz.reg_dest_E == hz.reg1_src_D || hz.reg_dest_E == hz.reg2_src_D);
    if (stall_all) begin
      bub = 5'b11110;
      fl  = 5'b00001;
    end else if (hz.br_taken_E || hz.jalr_E) begin
      fl  = 5'b01100;
    end else if (load_use) begin
      bub = 5'b11000;
      fl  = 5'b00100;
    end else if (hz.jal_D) begin
      fl  = 5'b01000;
    end
  end

  // Stall counter: clear wins, otherwise count bubbleF cycles up to all-ones.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stat_clr)                                 stall_cycles_d = '0;
    else if (bub[4] && stall_cycles_q != CNT_MAX) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  assign src_e[0] = hz.reg1_src_E;
  assign src_e[1] = hz.reg2_src_E;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    hazard_fwd u_fwd (
      .src_e  (src_e[g]),
      .dest_m (hz.reg_dest_M),
      .dest_w (hz.reg_dest_W),
      .wr_m   (hz.reg_write_M),
      .wr_w   (hz.reg_write_W),
      .sel    (fwd_sel[g])
    );
  end

  assign {hz.bubbleF, hz.bubbleD, hz.bubbleE, hz.bubbleM, hz.bubbleW} = bub;
  assign {hz.flushF,  hz.flushD,  hz.flushE,  hz.flushM,  hz.flushW}  = fl;
  assign hz.op1_sel    = fwd_sel[0];
  assign hz.op2_sel    = fwd_sel[1];
  assign err           = err_q;
  assign stall_cycles  = stall_cycles_q;
endmodule
